// File: rtl/test_harness_pkg.sv
// Shared types and default timing constants for the Synthesijer test sequencer.
package test_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUT_RST,
    ST_WAIT,
    ST_ISSUE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef logic [31:0] cnt_t;

  localparam int unsigned DEF_RESET_CYCLES = 6;
  localparam int unsigned DEF_START_DELAY  = 92;
  localparam int unsigned DEF_GUARD        = 4;
  localparam cnt_t        DEF_TIMEOUT      = 32'd1000000;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/test_harness_ch.sv
// One request channel: guard window after issue, then the first non-busy cycle
// captures the return value; abort forces any unfinished channel to fail.
module test_harness_ch
  import test_harness_pkg::*;
#(
  parameter int unsigned GUARD = DEF_GUARD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic issue,
  input  logic abort,
  input  logic busy,
  input  logic ret,
  output logic complete,
  output logic fail
);

  localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  logic [GW-1:0] guard_reg;
  logic          active_reg;
  logic          complete_reg;
  logic          fail_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      guard_reg    <= '0;
      active_reg   <= 1'b0;
      complete_reg <= 1'b0;
      fail_reg     <= 1'b0;
    end else if (clear) begin
      guard_reg    <= '0;
      active_reg   <= 1'b0;
      complete_reg <= 1'b0;
      fail_reg     <= 1'b0;
    end else if (abort) begin
      // Abort wins even over a completion sampled in the same cycle.
      if (!complete_reg) begin
        complete_reg <= 1'b1;
        fail_reg     <= 1'b1;
      end
      active_reg <= 1'b0;
    end else if (issue) begin
      guard_reg    <= GW'(GUARD);
      active_reg   <= 1'b1;
      complete_reg <= 1'b0;
      fail_reg     <= 1'b0;
    end else if (active_reg) begin
      if (guard_reg != '0) begin
        guard_reg <= guard_reg - GW'(1);
      end else if (!busy) begin
        complete_reg <= 1'b1;
        fail_reg     <= !ret;
        active_reg   <= 1'b0;
      end
    end
  end

  assign complete = complete_reg;
  assign fail     = fail_reg;

endmodule

// File: rtl/test_harness_seq.sv
// Test sequencer top: DUT reset, parallel/sequential request issue, timeout, results.
// Optional TEST_HARNESS_SEQ_TRACE_EN adds simulation-only progress messages.
module test_harness_seq
  import test_harness_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned START_DELAY  = DEF_START_DELAY,
  parameter int unsigned GUARD        = DEF_GUARD,
  parameter cnt_t        TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              seq_mode,
  output logic              dut_reset,
  output logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] busy,
  input  logic [NUM_CH-1:0] ret,
  output logic              done,
  output logic              pass,
  output logic [NUM_CH-1:0] fail_mask,
  output logic              timeout_flag,
  output logic [31:0]       cycles
);

  localparam int unsigned     IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam cnt_t            RST_LAST  = cnt_t'(RESET_CYCLES - 1);
  localparam cnt_t            WAIT_LAST = cnt_t'(START_DELAY - 1);
  localparam cnt_t            TMO_LAST  = TIMEOUT - 32'd1;

  state_t           state_reg, state_next;
  cnt_t             cnt_reg, cnt_next;
  cnt_t             timer_reg, timer_next;
  cnt_t             cycles_reg, cycles_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             seq_reg, seq_next;
  logic             tflag_reg, tflag_next;
  logic             clear_ch;
  logic             timeout_hit;
  logic             run_done;

  logic [NUM_CH-1:0] issue_vec;
  logic [NUM_CH-1:0] complete_vec;
  logic [NUM_CH-1:0] fail_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign issue_vec[gi] = (state_reg == ST_ISSUE) &&
                             (!seq_reg || (idx_reg == IDX_W'(gi)));

      test_harness_ch #(
        .GUARD(GUARD)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_ch),
        .issue   (issue_vec[gi]),
        .abort   (timeout_hit),
        .busy    (busy[gi]),
        .ret     (ret[gi]),
        .complete(complete_vec[gi]),
        .fail    (fail_vec[gi])
      );
    end
  endgenerate

  // Sequential mode waits only on the channel currently in flight.
  assign run_done = seq_reg ? complete_vec[idx_reg] : (&complete_vec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      timer_reg  <= '0;
      cycles_reg <= '0;
      idx_reg    <= '0;
      seq_reg    <= 1'b0;
      tflag_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      timer_reg  <= timer_next;
      cycles_reg <= cycles_next;
      idx_reg    <= idx_next;
      seq_reg    <= seq_next;
      tflag_reg  <= tflag_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    timer_next  = timer_reg;
    cycles_next = cycles_reg;
    idx_next    = idx_reg;
    seq_next    = seq_reg;
    tflag_next  = tflag_reg;
    clear_ch    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next  = ST_DUT_RST;
          cnt_next    = '0;
          timer_next  = '0;
          cycles_next = '0;
          idx_next    = '0;
          seq_next    = seq_mode;
          tflag_next  = 1'b0;
          clear_ch    = 1'b1;
        end
      end
      ST_DUT_RST: begin
        if (cnt_reg == RST_LAST) begin
          cnt_next   = '0;
          state_next = (START_DELAY == 0) ? ST_ISSUE : ST_WAIT;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_ISSUE, ST_RUN: begin
        timer_next  = timer_reg + 32'd1;
        cycles_next = sat_inc(cycles_reg);
        if (timer_reg == TMO_LAST) begin
          timeout_hit = 1'b1;
          tflag_next  = 1'b1;
          state_next  = ST_DONE;
        end else if (state_reg == ST_ISSUE) begin
          state_next = ST_RUN;
        end else if (run_done) begin
          if (seq_reg && (idx_reg != LAST_IDX)) begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dut_reset    = (state_reg == ST_DUT_RST);
  assign req          = issue_vec;
  assign done         = (state_reg == ST_DONE);
  assign fail_mask    = fail_vec;
  assign timeout_flag = tflag_reg;
  assign cycles       = cycles_reg;
  assign pass         = done && (fail_vec == '0) && !tflag_reg;

`ifdef TEST_HARNESS_SEQ_TRACE_EN
  logic [NUM_CH-1:0] trace_complete_d;
  state_t            trace_state_d;

  always_ff @(posedge clk) begin
    trace_complete_d <= complete_vec;
    trace_state_d    <= state_reg;
    for (int i = 0; i < NUM_CH; i++) begin
      if (complete_vec[i] && !trace_complete_d[i])
        $display("ch %0d: %s at cycle %0d", i, fail_vec[i] ? "FAIL" : "PASS", cycles_reg);
    end
    if (timeout_hit)
      $display("timeout at cycle %0d", cycles_reg + 32'd1);
    if (state_reg == ST_DONE && trace_state_d != ST_DONE)
      $display("%s", pass ? "TEST SUCCESS" : "TEST *** FAILURE ***");
  end
`endif

endmodule
